// File: rtl/serial_output_stream_pkg.sv
// Shared definitions for the serial stream blocks: frame state encoding and
// framing constants. The PARITY state is always declared so that the encoding
// is identical whether or not SERIAL_OUTPUT_PARITY_EN is defined.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_output_stream_baud_tick_generator.sv
// Baud tick generator: a one-cycle tick every DIVIDER clocks.
// While clear is high the counter is held at zero. The first tick therefore
// arrives exactly DIVIDER cycles after clear drops. The same block is meant to
// be shared with the matching serial receiver.
module baud_tick_generator #(
  parameter int DIVIDER = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIVIDER-1 and wrap; clear and reset restart the bit period.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/serial_output_stream.sv
// UART transmitter for a 32-bit stb/ack stream. Each accepted word sends its
// low byte as 8N1, LSB first. Define SERIAL_OUTPUT_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module serial_output_stream
  import serial_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DIVIDER         = CLOCK_FREQUENCY / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_data_stb,
  output logic        in_data_ack,
  output logic        tx,
  output logic        busy
);

  // A bit period shorter than two clocks cannot be timed by the divider.
  if (DIVIDER < 2) begin : g_divider_check
    $error("serial_output_stream: DIVIDER must be at least 2");
  end

  state_t      r_state;
  logic        r_tx;
  logic        r_ack;
  logic        r_busy;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
`ifdef SERIAL_OUTPUT_PARITY_EN
  logic        r_parity;
`endif

  logic        w_tick;
  logic        w_clear;
  logic        w_unused_upper;

  // The stream carries 32 bits, but only the low byte goes on the wire.
  assign w_unused_upper = ^in_data[31:8];

  // Hold the bit timer at zero in IDLE. This lets the start bit begin a
  // full DIVIDER period right at the transfer edge.
  assign w_clear = (r_state == IDLE);

  baud_tick_generator #(.DIVIDER(DIVIDER)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Frame sequencer: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= IDLE_LEVEL;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef SERIAL_OUTPUT_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b1;
          if (in_data_stb && r_ack) begin
            r_shift  <= in_data[7:0];
`ifdef SERIAL_OUTPUT_PARITY_EN
            r_parity <= ^in_data[7:0];
`endif
            r_ack    <= 1'b0;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_OUTPUT_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx    <= IDLE_LEVEL;
              r_state <= STOP;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef SERIAL_OUTPUT_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ack   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign in_data_ack = r_ack;
  assign busy        = r_busy;

endmodule

// File: tb/tb_serial_output_stream.sv
// Testbench for serial_output_stream, using DIVIDER = 10 (50 Hz clock, 5 baud).
// The expected line level for every cycle of a frame comes from the UART
// framing rule: start 0, data LSB first, optional even parity, then stop 1.
module tb_serial_output_stream;

  localparam int D = 10;
`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_data_stb = 1'b0;
  logic        in_data_ack;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  serial_output_stream #(
    .CLOCK_FREQUENCY(50),
    .BAUD_RATE      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_data_stb(in_data_stb),
    .in_data_ack(in_data_ack),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Line level of bit slot idx of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NB == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Offer word w and return at the negedge that follows the transfer edge.
  task automatic start_xfer(input logic [31:0] w);
    int t;
    @(negedge clk);
    in_data     = w;
    in_data_stb = 1'b1;
    t = 0;
    while (in_data_ack !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_data_ack !== 1'b1) begin
      errors++;
      $display("FAIL start_xfer_timeout ack=%b required=1", in_data_ack);
    end
    @(negedge clk);
  endtask

  // Check every cycle of a frame, starting at the negedge after the transfer
  // edge, and then the idle state right after the frame ends.
  task automatic check_frame(input logic [7:0] b, input string name, input bit scramble);
    logic e;
    for (int k = 0; k < NB*D; k++) begin
      e = exp_bit(b, k / D);
      checks++;
      if (tx !== e) begin
        errors++;
        $display("FAIL %s tx cycle=%0d got=%b required=%b", name, k, tx, e);
      end
      checks++;
      if (busy !== 1'b1 || in_data_ack !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/ack cycle=%0d got=%b/%b required=1/0", name, k, busy, in_data_ack);
      end
      if (scramble) in_data = $urandom;
      @(negedge clk);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_data_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s end_of_frame tx/busy/ack got=%b/%b/%b required=1/0/1",
               name, tx, busy, in_data_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_data_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx/busy/ack got=%b/%b/%b required=1/0/0", tx, busy, in_data_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_data_ack !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_release tx/busy/ack got=%b/%b/%b required=1/0/1", tx, busy, in_data_ack);
    end
  endtask

  task automatic test_idle();
    in_data_stb = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      in_data = $urandom;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || in_data_ack !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle=%0d tx/ack/busy got=%b/%b/%b required=1/1/0",
                 i, tx, in_data_ack, busy);
      end
    end
  endtask

  task automatic test_basic();
    start_xfer(32'h0000_0055);
    in_data_stb = 1'b0;
    check_frame(8'h55, "frame_55", 1'b1);
    start_xfer(32'hFFFF_FF41);
    in_data_stb = 1'b0;
    check_frame(8'h41, "frame_41_upper", 1'b1);
  endtask

  task automatic test_back_to_back();
    start_xfer(32'h0000_0012);
    in_data = 32'h0000_0034;
    check_frame(8'h12, "b2b_first", 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0 || in_data_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_at_101 busy/tx/ack got=%b/%b/%b required=1/0/0",
               busy, tx, in_data_ack);
    end
    in_data_stb = 1'b0;
    check_frame(8'h34, "b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    start_xfer(32'h0000_00A5);
    in_data_stb = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_data_ack !== 1'b0) begin
      errors++;
      $display("FAIL midreset tx/busy/ack got=%b/%b/%b required=1/0/0", tx, busy, in_data_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_data_ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release ack/busy got=%b/%b required=1/0", in_data_ack, busy);
    end
    start_xfer(32'h0000_003C);
    in_data_stb = 1'b0;
    check_frame(8'h3C, "after_reset_3C", 1'b1);
  endtask

`ifdef SERIAL_OUTPUT_PARITY_EN
  task automatic test_parity();
    start_xfer(32'h0000_0007);
    in_data_stb = 1'b0;
    check_frame(8'h07, "parity_07", 1'b1);
    start_xfer(32'h0000_0003);
    in_data_stb = 1'b0;
    check_frame(8'h03, "parity_03", 1'b1);
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_xfer(w);
      in_data_stb = 1'b0;
      check_frame(w[7:0], $sformatf("random_%0d", i), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SERIAL_OUTPUT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
